// File: rtl/adc_audio_sampler.sv
// rtl/adc_audio_sampler.sv - MCP3202-style dual-channel ADC SPI master producing signed 16-bit PCM pairs
module adc_audio_sampler #(
  parameter int CLK_DIV       = 4,
  parameter int SAMPLE_PERIOD = 281
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        enable,
  input  logic        adc_miso,
  output logic        adc_clk,
  output logic        adc_cs,
  output logic        adc_mosi,
  output logic [15:0] sample_left,
  output logic [15:0] sample_right,
  output logic        sample_strobe,
  output logic        busy
);

  localparam int CNT_W = (SAMPLE_PERIOD > 1) ? $clog2(SAMPLE_PERIOD) : 1;
  localparam int DIV_W = $clog2(CLK_DIV);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SAMPLE_PERIOD - 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [4:0]       BIT_LAST = 5'd16;
  localparam logic [4:0]       BIT_D11  = 5'd5;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETUP,
    S_SHIFT,
    S_HOLD
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [4:0]       bit_q, bit_d;
  logic             high_q, high_d;
  logic             chan_q, chan_d;
  logic [11:0]      code_q, code_d;
  logic [15:0]      stage_q, stage_d;
  logic [15:0]      left_q, left_d;
  logic [15:0]      right_q, right_d;
  logic             strobe_q, strobe_d;
  logic             cs_q, cs_d;
  logic             sclk_q, sclk_d;
  logic             mosi_q, mosi_d;

  logic             tick;
  logic             div_done;
  logic [15:0]      pcm;

  // Command word: start, single-ended, channel select, MSB-first, then zeros.
  function automatic logic mosi_bit(input logic [4:0] k, input logic ch);
    case (k)
      5'd0, 5'd1, 5'd3: mosi_bit = 1'b1;
      5'd2:             mosi_bit = ch;
      default:          mosi_bit = 1'b0;
    endcase
  endfunction

  assign tick     = (cnt_q == '0);
  assign div_done = (div_q == DIV_LAST);
  // Offset-binary to two's complement: flip the MSB, left-justify into 16 bits.
  assign pcm      = {~code_q[11], code_q[10:0], 4'b0000};

  // Free-running sample period counter; frames launch when it reads zero.
  always_comb begin
    cnt_d = (cnt_q == CNT_LAST) ? '0 : cnt_q + 1'b1;
  end

  // Frame sequencer: next state plus registered SPI pins and sample outputs.
  always_comb begin
    state_d  = state_q;
    div_d    = div_q;
    bit_d    = bit_q;
    high_d   = high_q;
    chan_d   = chan_q;
    code_d   = code_q;
    stage_d  = stage_q;
    left_d   = left_q;
    right_d  = right_q;
    strobe_d = 1'b0;
    cs_d     = cs_q;
    sclk_d   = sclk_q;
    mosi_d   = mosi_q;

    case (state_q)
      S_IDLE: begin
        cs_d   = 1'b1;
        sclk_d = 1'b0;
        mosi_d = 1'b0;
        div_d  = '0;
        if (tick) begin
          if (enable) begin
            state_d = S_SETUP;
            cs_d    = 1'b0;
          end else begin
            // Restart on the left channel whenever sampling is paused.
            chan_d = 1'b0;
          end
        end
      end

      S_SETUP: begin
        div_d = div_q + 1'b1;
        if (div_done) begin
          state_d = S_SHIFT;
          div_d   = '0;
          bit_d   = '0;
          high_d  = 1'b0;
          mosi_d  = mosi_bit(5'd0, chan_q);
        end
      end

      S_SHIFT: begin
        div_d = div_q + 1'b1;
        if (div_done) begin
          div_d = '0;
          if (!high_q) begin
            // Rising adc_clk edge: capture data bits, skip the null bit and command bits.
            high_d = 1'b1;
            sclk_d = 1'b1;
            if (bit_q >= BIT_D11) begin
              code_d = {code_q[10:0], adc_miso};
            end
          end else if (bit_q == BIT_LAST) begin
            state_d = S_HOLD;
            high_d  = 1'b0;
            sclk_d  = 1'b0;
            mosi_d  = 1'b0;
          end else begin
            bit_d  = bit_q + 5'd1;
            high_d = 1'b0;
            sclk_d = 1'b0;
            mosi_d = mosi_bit(bit_q + 5'd1, chan_q);
          end
        end
      end

      S_HOLD: begin
        div_d = div_q + 1'b1;
        if (div_done) begin
          state_d = S_IDLE;
          div_d   = '0;
          cs_d    = 1'b1;
          if (chan_q) begin
            // Publish both channels together so the pair is never torn.
            left_d   = stage_q;
            right_d  = pcm;
            strobe_d = 1'b1;
            chan_d   = 1'b0;
          end else begin
            stage_d = pcm;
            chan_d  = 1'b1;
          end
        end
      end

      default: begin
        state_d = S_IDLE;
        cs_d    = 1'b1;
        sclk_d  = 1'b0;
        mosi_d  = 1'b0;
      end
    endcase
  end

  // State and output registers; reset forces the bus idle immediately.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      div_q    <= '0;
      bit_q    <= '0;
      high_q   <= 1'b0;
      chan_q   <= 1'b0;
      code_q   <= '0;
      stage_q  <= '0;
      left_q   <= '0;
      right_q  <= '0;
      strobe_q <= 1'b0;
      cs_q     <= 1'b1;
      sclk_q   <= 1'b0;
      mosi_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      div_q    <= div_d;
      bit_q    <= bit_d;
      high_q   <= high_d;
      chan_q   <= chan_d;
      code_q   <= code_d;
      stage_q  <= stage_d;
      left_q   <= left_d;
      right_q  <= right_d;
      strobe_q <= strobe_d;
      cs_q     <= cs_d;
      sclk_q   <= sclk_d;
      mosi_q   <= mosi_d;
    end
  end

  assign adc_cs        = cs_q;
  assign adc_clk       = sclk_q;
  assign adc_mosi      = mosi_q;
  assign sample_left   = left_q;
  assign sample_right  = right_q;
  assign sample_strobe = strobe_q;
  assign busy          = ~cs_q;

endmodule

// File: tb/tb_adc_audio_sampler.sv
// tb/tb_adc_audio_sampler.sv - scoreboard bench for adc_audio_sampler
module tb_adc_audio_sampler;

  localparam int CLK_DIV = 4;
  localparam int P       = 281;

  typedef struct packed {
    logic [11:0] code;
    logic        null_hi;
  } stim_t;

  typedef struct packed {
    logic [15:0] left;
    logic [15:0] right;
  } pair_t;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        enable;
  logic        adc_miso = 1'b0;
  logic        adc_clk;
  logic        adc_cs;
  logic        adc_mosi;
  logic [15:0] sample_left;
  logic [15:0] sample_right;
  logic        sample_strobe;
  logic        busy;

  adc_audio_sampler #(.CLK_DIV(CLK_DIV), .SAMPLE_PERIOD(P)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .enable       (enable),
    .adc_miso     (adc_miso),
    .adc_clk      (adc_clk),
    .adc_cs       (adc_cs),
    .adc_mosi     (adc_mosi),
    .sample_left  (sample_left),
    .sample_right (sample_right),
    .sample_strobe(sample_strobe),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  stim_t stim_q[$];
  logic  chan_q[$];
  pair_t exp_q[$];

  int    tests = 0;
  int    fails = 0;
  int    cyc = 0;
  int    frames_started = 0;
  int    rises = 0;
  int    low_cycles = 0;
  int    hi_cycles = 0;
  int    last_fall = 0;
  bit    have_fall = 0;
  bit    in_frame = 0;
  bit    prev_cs = 1;
  bit    prev_aclk = 0;
  bit    prev_strobe = 0;
  logic [4:0] mosi_bits = '0;
  stim_t cur = '0;
  pair_t last_pair = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic logic miso_for(input stim_t s, input int k);
    if (k == 4) return s.null_hi;
    if (k >= 5 && k <= 16) return s.code[16-k];
    return 1'b0;
  endfunction

  task automatic issue_frame(input logic [11:0] code, input logic null_hi, input logic ch);
    stim_t s;
    s.code    = code;
    s.null_hi = null_hi;
    stim_q.push_back(s);
    chan_q.push_back(ch);
  endtask

  task automatic expect_pair(input logic [15:0] l, input logic [15:0] r);
    pair_t p;
    p.left  = l;
    p.right = r;
    exp_q.push_back(p);
  endtask

  task automatic wait_k(input int frame, input int k, input string name);
    int i;
    i = 0;
    while (!(frames_started == frame && rises == k) && i < 20 * P) begin
      @(negedge clk);
      i++;
    end
    if (i >= 20 * P) begin
      tests++;
      fails++;
      $display("FAIL %s: timeout waiting for frame %0d bit %0d", name, frame, k);
    end
  endtask

  // ADC model and frame-shape monitor
  always @(negedge clk) begin
    int diff;
    logic ch;
    cyc++;
    if (!reset_n) begin
      in_frame  = 0;
      have_fall = 0;
      prev_cs   = 1;
      prev_aclk = 0;
      rises     = 0;
      adc_miso  = 1'b0;
    end else begin
      if (prev_cs && !adc_cs) begin
        in_frame   = 1;
        rises      = 0;
        low_cycles = 0;
        hi_cycles  = 0;
        mosi_bits  = '0;
        frames_started++;
        cur = (stim_q.size() != 0) ? stim_q.pop_front() : '0;
        if (have_fall) begin
          diff = cyc - last_fall;
          if (diff < 2 * P) check("fall_to_fall", diff, P);
          else check("fall_to_fall_mod", diff % P, 0);
        end
        last_fall = cyc;
        have_fall = 1;
      end
      if (!adc_cs) begin
        low_cycles++;
        if (adc_clk) hi_cycles++;
        if (adc_clk && !prev_aclk) begin
          if (rises < 5) mosi_bits[rises] = adc_mosi;
          rises++;
        end
      end
      if (!prev_cs && adc_cs && in_frame) begin
        in_frame = 0;
        check("cs_low_cycles", low_cycles, 36 * CLK_DIV);
        check("adc_clk_pulses", rises, 17);
        check("adc_clk_high_cycles", hi_cycles, 17 * CLK_DIV);
        if (chan_q.size() != 0) begin
          ch = chan_q.pop_front();
          check("mosi_cmd_bits", mosi_bits, {1'b0, 1'b1, ch, 1'b1, 1'b1});
          if (ch) begin
            check("strobe_at_right_end", sample_strobe, 1);
          end else begin
            check("no_strobe_at_left_end", sample_strobe, 0);
            check("left_held", sample_left, last_pair.left);
            check("right_held", sample_right, last_pair.right);
          end
        end
      end
      if (!adc_clk) adc_miso = miso_for(cur, rises);
      prev_cs   = adc_cs;
      prev_aclk = adc_clk;
    end
  end

  // Output monitor: every strobe must match the next expected pair
  always @(negedge clk) begin
    pair_t e;
    if (!reset_n) begin
      prev_strobe = 0;
    end else begin
      if (sample_strobe) begin
        if (prev_strobe) check("strobe_width", 2, 1);
        if (exp_q.size() == 0) begin
          check("unexpected_strobe", 1, 0);
        end else begin
          e = exp_q.pop_front();
          check("sample_left", sample_left, e.left);
          check("sample_right", sample_right, e.right);
          last_pair = e;
        end
      end
      prev_strobe = sample_strobe;
    end
  end

  initial begin
    int base;
    stim_t dummy;
    reset_n = 1'b0;
    enable  = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_adc_cs", adc_cs, 1);
    check("rst_adc_clk", adc_clk, 0);
    check("rst_adc_mosi", adc_mosi, 0);
    check("rst_sample_left", sample_left, 0);
    check("rst_sample_right", sample_right, 0);
    check("rst_sample_strobe", sample_strobe, 0);
    check("rst_busy", busy, 0);

    // Frame that will be cut short by reset during bit 7
    dummy.code    = 12'h555;
    dummy.null_hi = 1'b0;
    stim_q.push_back(dummy);
    enable = 1'b1;
    base   = frames_started;
    #2 reset_n = 1'b1;
    @(negedge clk);
    check("first_frame_at_wrap", adc_cs, 0);
    wait_k(base + 1, 7, "wait_abort_point");
    #2 reset_n = 1'b0;
    #1;
    check("abort_adc_cs", adc_cs, 1);
    check("abort_adc_clk", adc_clk, 0);
    check("abort_busy", busy, 0);
    repeat (2) @(negedge clk);

    issue_frame(12'hFFF, 1'b0, 1'b0);
    issue_frame(12'h000, 1'b0, 1'b1);
    expect_pair(16'h7FF0, 16'h8000);
    issue_frame(12'h800, 1'b0, 1'b0);
    issue_frame(12'h001, 1'b0, 1'b1);
    expect_pair(16'h0000, 16'h8010);
    issue_frame(12'h123, 1'b0, 1'b0);
    issue_frame(12'h456, 1'b0, 1'b1);
    expect_pair(16'h9230, 16'hC560);
    issue_frame(12'h000, 1'b1, 1'b0);
    issue_frame(12'hABC, 1'b0, 1'b1);
    expect_pair(16'h8000, 16'h2BC0);
    issue_frame(12'h7FF, 1'b0, 1'b0);
    issue_frame(12'h801, 1'b0, 1'b1);
    expect_pair(16'hFFF0, 16'h0010);

    base = frames_started;
    #2 reset_n = 1'b1;
    @(negedge clk);
    check("restart_at_wrap", adc_cs, 0);
    wait_k(base + 10, 10, "wait_enable_drop");
    enable = 1'b0;

    base = frames_started;
    repeat (3 * P) @(negedge clk);
    check("no_frames_while_disabled", frames_started, base);
    check("pairs_after_disable", exp_q.size(), 0);

    issue_frame(12'h3C0, 1'b0, 1'b0);
    issue_frame(12'hC3F, 1'b0, 1'b1);
    expect_pair(16'hBC00, 16'h43F0);
    enable = 1'b1;
    wait_k(base + 2, 1, "wait_final_right");
    enable = 1'b0;

    for (int i = 0; i < 3 * P && exp_q.size() != 0; i++) @(negedge clk);
    check("pairs_drained", exp_q.size(), 0);
    check("frames_drained", chan_q.size(), 0);
    repeat (P) @(negedge clk);
    check("final_left_held", sample_left, 16'hBC00);
    check("final_right_held", sample_right, 16'h43F0);
    check("final_idle_cs", adc_cs, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
